seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive side of the seven-segment display interface. Samples a multiplexed display bus
//  (8-bit segment pattern plus one-hot digit enables), debounces each digit dwell and
//  decodes each pattern back to a hex nibble.
//  - Assembles DIGITS nibbles into one word and strobes it once per complete scan frame.
//  - Used to loop back and check LED encoder output, and to read external display drivers.
// PARAMETERS
//  DIGITS          4   number of multiplexed digits (1..8)
//  STABLE_CYCLES   4   consecutive unchanged cycles required before a capture (>=2)
//  SEG_ACTIVE_LOW  0   1: invert segIn before decoding (common-anode drivers)
// PORTS
//  clk          in   1           single clock, all logic on rising edge
//  rst          in   1           synchronous, active-high reset
//  segIn        in   8           [7]=dp, [6:0]=g..a segment lines
//  digEn        in   DIGITS      digit enables, active-high, expected one-hot
//  value        out  4*DIGITS    decoded word, digit i in value[4i+3:4i]
//  frameValid   out  1           one-cycle strobe: value/dpOut/frameErr just updated
//  frameErr     out  1           valid with frameValid: >=1 digit in frame had illegal pattern
//  badPattern   out  1           one-cycle pulse at capture of an illegal pattern
//  dpOut        out  DIGITS      decimal-point state per digit (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: value=0, frameValid=0, frameErr=0, badPattern=0, dpOut=0.
//    Capture mask, slots, stability counter and input registers are cleared.
//    A reset mid-frame discards the partial frame.
//  - Input stage: segIn/digEn registered once (segQ/enQ). Segment polarity is applied after this register.
//  - Stability: stableCnt clears when {segQ,enQ} differs from the previous cycle.
//    Otherwise it increments and saturates at STABLE_CYCLES.
//  - Capture: fires exactly once per dwell, on the cycle stableCnt reaches STABLE_CYCLES-1.
//    The dwell must also have enQ exactly one-hot.
//    A pair presented at the pins from edge k is written to its slot at edge k+STABLE_CYCLES.
//  - No capture when enQ is zero or multi-hot. Blanking gaps between digits are therefore legal.
//  - Decode: 7-bit pattern (a=bit0) to nibble. Legal patterns only:
//      0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//    Any other pattern stores nibble 0, pulses badPattern the cycle after capture, and sets the frame error flag.
//  - Frame: each capture sets the mask bit for that digit.
//    Recapturing a digit already in the mask overwrites its slot and leaves the mask unchanged.
//    When a capture completes the mask (all ones):
//      - next edge: value/dpOut <= slots including the new digit, frameErr <= error flag,
//        frameValid=1 for one cycle;
//      - on that same edge: mask and error flag clear.
//  - value holds between frames. Digit order within a frame is irrelevant.
//  - Simultaneous: a capture on the cycle frameValid is high belongs to the next frame.
//  - Latency: the final digit's pins stable at edge k -> frameValid high after edge k+STABLE_CYCLES+1.
// CONFIGURATION
//  DP_CAPTURE_EN defined:
//    - dp bit (post-polarity) is stored per slot and presented on dpOut with each frame.
//    - dp changes participate in the stability comparison.
//  DP_CAPTURE_EN undefined:
//    - dp bit is masked before the stability comparison and decode.
//    - dpOut is tied to 0. The port remains for interface stability.
// STRUCTURE
//  Package seg7_pkg:
//    - localparams for the 16 legal segment codes and the SEG_DP index (7);
//    - function seg_to_nibble(input [6:0]) returning {legal, nibble[3:0]}.
//    The encoder also uses this package.
//  Sub-module seg7_pattern_decode: combinational wrapper around seg_to_nibble. The top holds the
//  input regs, stability counter, one-hot check, slots, mask and output regs.
// TESTING
//  1. Reset then hold digEn=0001, segIn=0x5B for 4 cycles, then 0010/0x4F, 0100/0x66, 1000/0x6D
//     -> badPattern never pulses, and one frameValid pulse with value=0x5432, frameErr=0.
//  2. digEn=0001 with segIn toggling 0x06/0x07 every 2 cycles -> no capture, no frameValid.
//     Then hold 0x07 for 4 cycles -> slot0=7.
//  3. Frame with digit2 segIn=0x49 (illegal) -> badPattern pulse, value[11:8]=0, frameErr=1.
//     Next clean frame -> frameErr=0.
//  4. digEn=0011 for 10 cycles, and digEn=0000 gaps between digits -> no captures from them.
//     The frame still completes correctly around the gaps.
//  5. Capture 3 digits, assert rst one cycle, then send one full frame
//     -> value=0 until the new frame, which alone produces frameValid.
//  6. DP_CAPTURE_EN builds: segIn=0x86 on digit0 -> dpOut[0]=1, value[3:0]=1.
//     Without the macro -> dpOut=0, value[3:0]=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Purpose: shared seven-segment code table and pattern-to-nibble decode helper.
// Latency: n/a (constants and a combinational function only).
// Backpressure: none; also imported by the LED encoder side.
package seg7_pkg;

  // Index of the decimal-point line within the 8-bit segment bus.
  localparam int SEG_DP = 7;

  // Legal 7-bit patterns, segment a on bit 0 through g on bit 6.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Returns {legal, nibble}; unknown patterns give {0, 4'h0}.
  function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'h00;
    case (seg)
      SEG_0: res = {1'b1, 4'h0};
      SEG_1: res = {1'b1, 4'h1};
      SEG_2: res = {1'b1, 4'h2};
      SEG_3: res = {1'b1, 4'h3};
      SEG_4: res = {1'b1, 4'h4};
      SEG_5: res = {1'b1, 4'h5};
      SEG_6: res = {1'b1, 4'h6};
      SEG_7: res = {1'b1, 4'h7};
      SEG_8: res = {1'b1, 4'h8};
      SEG_9: res = {1'b1, 4'h9};
      SEG_A: res = {1'b1, 4'hA};
      SEG_B: res = {1'b1, 4'hB};
      SEG_C: res = {1'b1, 4'hC};
      SEG_D: res = {1'b1, 4'hD};
      SEG_E: res = {1'b1, 4'hE};
      SEG_F: res = {1'b1, 4'hF};
      default: res = 5'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Purpose: decode one 7-bit segment pattern to a hex nibble plus legality flag.
// Latency: combinational, zero cycles.
// Backpressure: none.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  // Table lookup shared with the encoder through the package.
  always_comb begin
    {legal, nibble} = seg_to_nibble(seg);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Purpose: sample a multiplexed 7-seg bus, debounce each digit dwell, rebuild the DIGITS-nibble word.
// Latency: last digit pins stable at edge k -> frameValid after edge k+STABLE_CYCLES+1.
// Backpressure: none; one frame strobe per completed scan. Option macro: DP_CAPTURE_EN (dp capture).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            segIn,
  input  logic [DIGITS-1:0]     digEn,
  output logic [4*DIGITS-1:0]   value,
  output logic                  frameValid,
  output logic                  frameErr,
  output logic                  badPattern,
  output logic [DIGITS-1:0]     dpOut
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  // Capture fires on the cycle whose increment lands the counter on STABLE_CYCLES-1.
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 2);
`ifdef DP_CAPTURE_EN
  localparam logic DP_KEEP = 1'b1;
`else
  localparam logic DP_KEEP = 1'b0;
`endif

  logic [7:0]          seg_q, seg_d, prev_seg_q, prev_seg_d;
  logic [DIGITS-1:0]   en_q, en_d, prev_en_q, prev_en_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] slot_q, slot_d, value_q, value_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                err_q, err_d, done_q, done_d;
  logic                fv_q, fv_d, ferr_q, ferr_d, bad_q, bad_d;
  logic [7:0]          seg_cmp;
  logic                same, one_hot, fire, legal;
  logic [3:0]          nibble;

  seg7_pattern_decode u_decode (
    .seg    (seg_cmp[6:0]),
    .legal  (legal),
    .nibble (nibble)
  );

  // Polarity fix-up, dp masking, dwell stability and one-hot qualification.
  always_comb begin
    seg_cmp    = ((SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q) & {DP_KEEP, 7'h7F};
    same       = (seg_cmp == prev_seg_q) && (en_q == prev_en_q);
    one_hot    = (en_q != '0) && ((en_q & (en_q - DIGITS'(1))) == '0);
    fire       = same && (cnt_q == CNT_FIRE) && one_hot;
    seg_d      = segIn;
    en_d       = digEn;
    prev_seg_d = seg_cmp;
    prev_en_d  = en_q;
    cnt_d      = '0;
    if (same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Slot writes, frame mask/error accumulation and output staging.
  always_comb begin
    slot_d = slot_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (fire && en_q[i]) begin
        slot_d[4*i +: 4] = nibble;
      end
    end
    // A completed frame clears the mask on the output edge; a capture on that edge starts the next frame.
    mask_d  = (done_q ? '0 : mask_q) | (fire ? en_q : '0);
    err_d   = (done_q ? 1'b0 : err_q) | (fire && !legal);
    done_d  = fire && (mask_d == {DIGITS{1'b1}});
    bad_d   = fire && !legal;
    fv_d    = done_q;
    value_d = done_q ? slot_q : value_q;
    ferr_d  = done_q ? err_q : ferr_q;
  end

  // Main state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= '0;
      en_q       <= '0;
      prev_seg_q <= '0;
      prev_en_q  <= '0;
      cnt_q      <= '0;
      slot_q     <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      value_q    <= '0;
      fv_q       <= 1'b0;
      ferr_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      en_q       <= en_d;
      prev_seg_q <= prev_seg_d;
      prev_en_q  <= prev_en_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      done_q     <= done_d;
      value_q    <= value_d;
      fv_q       <= fv_d;
      ferr_q     <= ferr_d;
      bad_q      <= bad_d;
    end
  end

`ifdef DP_CAPTURE_EN
  logic [DIGITS-1:0] dp_slot_q, dp_slot_d, dp_q, dp_d;

  // Per-digit decimal-point capture and presentation with each frame.
  always_comb begin
    dp_slot_d = dp_slot_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (fire && en_q[i]) begin
        dp_slot_d[i] = seg_cmp[SEG_DP];
      end
    end
    dp_d = done_q ? dp_slot_q : dp_q;
  end

  // Decimal-point registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_slot_q <= '0;
      dp_q      <= '0;
    end else begin
      dp_slot_q <= dp_slot_d;
      dp_q      <= dp_d;
    end
  end

  assign dpOut = dp_q;
`else
  assign dpOut = '0;
`endif

  assign value      = value_q;
  assign frameValid = fv_q;
  assign frameErr   = ferr_q;
  assign badPattern = bad_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Purpose: scoreboard bench for seg7_scan_decoder; expected frames queued at stimulus, popped on frameValid.
// Latency: checks first-frame strobe timing against pin-stable edge + STABLE_CYCLES + 1.
// Backpressure: n/a; honours DP_CAPTURE_EN for the expected dpOut.
module tb_seg7_scan_decoder;

  typedef struct {
    logic [15:0] value;
    logic        err;
    logic [3:0]  dp;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  segIn;
  logic [3:0]  digEn;
  logic [15:0] value;
  logic        frameValid, frameErr, badPattern;
  logic [3:0]  dpOut;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bad_seen = 0;
  int   bad0;

`ifdef DP_CAPTURE_EN
  localparam logic [3:0] EXP_DP6 = 4'b0001;
`else
  localparam logic [3:0] EXP_DP6 = 4'b0000;
`endif

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4), .SEG_ACTIVE_LOW(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .segIn      (segIn),
    .digEn      (digEn),
    .value      (value),
    .frameValid (frameValid),
    .frameErr   (frameErr),
    .badPattern (badPattern),
    .dpOut      (dpOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a pin pair for n rising edges (called just after a falling edge).
  task automatic hold(input logic [3:0] en, input logic [7:0] seg, input int n);
    digEn = en;
    segIn = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                       input logic [7:0] s3, input int gap);
    hold(4'b0001, s0, 4);
    if (gap > 0) hold(4'b0000, 8'h00, gap);
    hold(4'b0010, s1, 4);
    if (gap > 0) hold(4'b0000, 8'h00, gap);
    hold(4'b0100, s2, 4);
    if (gap > 0) hold(4'b0000, 8'h00, gap);
    hold(4'b1000, s3, 4);
    hold(4'b0000, 8'h00, 3);
  endtask

  task automatic push(input logic [15:0] v, input logic e, input logic [3:0] dp, input int c);
    exp_t x;
    x.value = v;
    x.err   = e;
    x.dp    = dp;
    x.cyc   = c;
    sb.push_back(x);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  // Output monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (badPattern) bad_seen++;
    if (frameValid) begin
      if (sb.size() == 0) begin
        chk("spurious_frame", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("value", value, mon_e.value);
        chk("frame_err", frameErr, mon_e.err);
        chk("dp_out", dpOut, mon_e.dp);
        if (mon_e.cyc > 0) chk("latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    segIn = 8'h00;
    digEn = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_value", value, 0);
    chk("rst_frame_valid", frameValid, 0);
    chk("rst_frame_err", frameErr, 0);
    chk("rst_bad_pattern", badPattern, 0);
    chk("rst_dp_out", dpOut, 0);
    rst = 1'b0;
    hold(4'b0000, 8'h00, 2);

    // 1: back-to-back dwells, checks value and strobe latency
    bad0 = bad_seen;
    hold(4'b0001, 8'h5B, 4);
    hold(4'b0010, 8'h4F, 4);
    hold(4'b0100, 8'h66, 4);
    push(16'h5432, 1'b0, 4'b0000, cyc + 6);
    hold(4'b1000, 8'h6D, 4);
    hold(4'b0000, 8'h00, 3);
    drain("t1_drain");
    chk("t1_bad_count", bad_seen - bad0, 0);

    // 2: short dwells on the final digit must never capture
    hold(4'b0010, 8'h06, 4);
    hold(4'b0100, 8'h5B, 4);
    hold(4'b1000, 8'h4F, 4);
    repeat (4) begin
      hold(4'b0001, 8'h06, 2);
      hold(4'b0001, 8'h07, 2);
    end
    hold(4'b0001, 8'h06, 2);
    push(16'h3217, 1'b0, 4'b0000, 0);
    hold(4'b0001, 8'h07, 4);
    hold(4'b0000, 8'h00, 3);
    drain("t2_drain");

    // 3: illegal pattern on digit 2, then a clean frame clears the error
    bad0 = bad_seen;
    push(16'h7049, 1'b1, 4'b0000, 0);
    frame(8'h6F, 8'h66, 8'h49, 8'h07, 0);
    drain("t3_drain");
    chk("t3_bad_count", bad_seen - bad0, 1);
    push(16'h8E1F, 1'b0, 4'b0000, 0);
    frame(8'h71, 8'h06, 8'h79, 8'h7F, 0);
    drain("t3_clean_drain");

    // 4: multi-hot dwell and blanking gaps are ignored
    push(16'h3210, 1'b0, 4'b0000, 0);
    hold(4'b0011, 8'h7F, 10);
    hold(4'b0000, 8'h00, 2);
    hold(4'b1000, 8'h4F, 4);
    hold(4'b0000, 8'h00, 3);
    hold(4'b0100, 8'h5B, 4);
    hold(4'b0000, 8'h00, 3);
    hold(4'b0010, 8'h06, 4);
    hold(4'b0000, 8'h00, 3);
    hold(4'b0001, 8'h3F, 4);
    hold(4'b0000, 8'h00, 3);
    drain("t4_drain");

    // 5: reset mid-frame discards the partial mask
    hold(4'b0001, 8'h5E, 4);
    hold(4'b0010, 8'h39, 4);
    hold(4'b0100, 8'h7C, 4);
    hold(4'b0000, 8'h00, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_value", value, 0);
    chk("t5_rst_frame_valid", frameValid, 0);
    hold(4'b1000, 8'h77, 4);
    hold(4'b0000, 8'h00, 6);
    chk("t5_value_hold", value, 0);
    push(16'hABCD, 1'b0, 4'b0000, 0);
    hold(4'b0001, 8'h5E, 4);
    hold(4'b0010, 8'h39, 4);
    hold(4'b0100, 8'h7C, 4);
    hold(4'b0000, 8'h00, 3);
    drain("t5_drain");

    // 6: decimal point on digit 0
    push(16'h3201, 1'b0, EXP_DP6, 0);
    frame(8'h86, 8'h3F, 8'h5B, 8'h4F, 2);
    drain("t6_drain");
    chk("final_value_hold", value, 32'h3201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
